// File: rtl/rr_arbiter4x16.sv
// rtl/rr_arbiter4x16.sv - round-robin 4:1 arbiter feeding a registered, flow-controlled output stage
module mux4way16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] out
);
   always_comb begin
      case (sel)
         2'd0:    out = a;
         2'd1:    out = b;
         2'd2:    out = c;
         default: out = d;
      endcase
   end
endmodule

module rr_arbiter4x16 #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [1:0]       r_ptr;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_out;
   logic             r_valid;

   logic             w_accept;
   logic             w_found;
   logic [1:0]       w_win;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_mux;

   // A word consumed at this edge may be replaced at the same edge.
   assign w_accept = rst_n && (!r_valid || out_ready);

   // Scan from the pointer; the first requester found wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   mux4way16 #(.WIDTH(WIDTH)) u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .sel (w_win),
      .out (w_mux)
   );

   assign gnt = (w_accept && w_found) ? (4'b0001 << w_win) : 4'b0000;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         if (w_found) begin
            r_out   <= w_mux;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_win + 2'd1;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign sel       = r_sel;
   assign out       = r_out;
   assign out_valid = r_valid;
endmodule
